// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Build option: define SEQ_DIV_OUT_PIPE_EN to add one output register stage.
package seq_div_pkg;

    localparam int unsigned DEF_N  = 192;
    localparam int unsigned DEF_CW = 8;
    localparam int unsigned MAX_W  = 1024;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    // Quotient cannot fit in N bits when the dividend's upper half already
    // reaches the divisor; a zero divisor always lands here.
    function automatic logic div_overflow(input logic [MAX_W-1:0] hi,
                                          input logic [MAX_W-1:0] d);
        return hi >= d;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider; master issues divisions, slave answers.
interface seq_divider_if
    import seq_div_pkg::*;
#(
    parameter int unsigned N = DEF_N
);

    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [N-1:0]     quotient;
    logic [N-1:0]     remainder;
    logic             ovf;
    logic             dz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, ovf, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, ovf, dz
    );

endinterface

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial subtract.
// The partial remainder's top bit is always zero between steps, so only N bits travel.
module seq_div_step #(
    parameter int unsigned N = 192
) (
    input  logic [N-1:0] r,
    input  logic         q_msb,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] r_next,
    output logic         q_bit
);

    logic [N:0] s;
    logic [N:0] t;

    // NOTE: every combinational output is assigned on every path, so no latch is inferred.
    always_comb begin
        s      = {r, q_msb};
        t      = s - {1'b0, divisor};
        q_bit  = ~t[N];
        r_next = q_bit ? t[N-1:0] : s[N-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Build option: SEQ_DIV_OUT_PIPE_EN adds one register stage on all result outputs.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned CW = DEF_CW
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);

    state_t          state;
    state_t          state_nxt;

    logic [N-1:0]    r_q;
    logic [N-1:0]    q_q;
    logic [N-1:0]    d_q;
    logic [CW-1:0]   cnt;
    logic            ovf_q;

    logic            load;
    logic            step;
    logic            fin;
    logic            start_ovf;

    logic [N-1:0]    r_nxt;
    logic            q_bit;

    logic [N-1:0]    quo_r;
    logic [N-1:0]    rem_r;
    logic            ovf_r;
    logic            dz_r;
    logic            done_r;

    assign start_ovf = div_overflow(MAX_W'(bus.dividend[2*N-1:N]), MAX_W'(bus.divisor));

    seq_div_step #(.N(N)) u_step (
        .r       (r_q),
        .q_msb   (q_q[N-1]),
        .divisor (d_q),
        .r_next  (r_nxt),
        .q_bit   (q_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = start_ovf ? FIN : CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load = (state == IDLE) && bus.start;
        step = (state == CALC);
        fin  = (state == FIN);
    end

    assign bus.busy = step;

    // In overflow the low dividend half parks in q_q and becomes the remainder.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (load) begin
            r_q   <= bus.dividend[2*N-1:N];
            q_q   <= bus.dividend[N-1:0];
            d_q   <= bus.divisor;
            cnt   <= CW'(N);
            ovf_q <= start_ovf;
        end else if (step) begin
            r_q   <= r_nxt;
            q_q   <= {q_q[N-2:0], q_bit};
            cnt   <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_r  <= '0;
            rem_r  <= '0;
            ovf_r  <= 1'b0;
            dz_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= fin;
            if (fin) begin
                if (ovf_q) begin
                    quo_r <= '1;
                    rem_r <= q_q;
                    ovf_r <= 1'b1;
                    dz_r  <= (d_q == '0);
                end else begin
                    quo_r <= q_q;
                    rem_r <= r_q;
                    ovf_r <= 1'b0;
                    dz_r  <= 1'b0;
                end
            end
        end
    end

`ifdef SEQ_DIV_OUT_PIPE_EN
    logic [N-1:0] quo_p;
    logic [N-1:0] rem_p;
    logic         ovf_p;
    logic         dz_p;
    logic         done_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_p  <= '0;
            rem_p  <= '0;
            ovf_p  <= 1'b0;
            dz_p   <= 1'b0;
            done_p <= 1'b0;
        end else begin
            quo_p  <= quo_r;
            rem_p  <= rem_r;
            ovf_p  <= ovf_r;
            dz_p   <= dz_r;
            done_p <= done_r;
        end
    end

    assign bus.quotient  = quo_p;
    assign bus.remainder = rem_p;
    assign bus.ovf       = ovf_p;
    assign bus.dz        = dz_p;
    assign bus.done      = done_p;
`else
    assign bus.quotient  = quo_r;
    assign bus.remainder = rem_r;
    assign bus.ovf       = ovf_r;
    assign bus.dz        = dz_r;
    assign bus.done      = done_r;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against a wide-arithmetic reference model.
// Honours SEQ_DIV_OUT_PIPE_EN for the expected latency.
module tb_seq_divider;
    import seq_div_pkg::*;

    localparam int N  = DEF_N;
    localparam int CW = DEF_CW;
`ifdef SEQ_DIV_OUT_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif
    localparam int LAT_CALC = N + 1 + PIPE;
    localparam int LAT_OVF  = 1 + PIPE;

    typedef logic [2*N-1:0] dw_t;
    typedef logic [N-1:0]   nw_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic nw_t rand_n();
        nw_t v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: plain wide division, overflow when the true quotient exceeds N bits.
    function automatic void ref_div(input dw_t dvd, input nw_t dvs,
                                    output nw_t q, output nw_t r,
                                    output logic ovf, output logic dz);
        dw_t full;
        dw_t dvs_w;
        dz = (dvs == '0);
        if (dz) begin
            ovf = 1'b1;
            q   = '1;
            r   = dvd[N-1:0];
        end else begin
            dvs_w = dw_t'(dvs);
            full  = dvd / dvs_w;
            ovf   = (full >> N) != '0;
            if (ovf) begin
                q = '1;
                r = dvd[N-1:0];
            end else begin
                q = full[N-1:0];
                r = nw_t'(dvd % dvs_w);
            end
        end
    endfunction

    task automatic start_op(input dw_t dvd, input nw_t dvs);
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 2 * N + 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = cyc - acc_cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        n_checks++;
        if (bus.ovf !== 1'b0 || bus.dz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ovf=%b dz=%b, want 0 0", bus.ovf, bus.dz);
        end
        n_checks++;
        if (bus.quotient !== '0 || bus.remainder !== '0) begin
            n_fail++;
            $display("FAIL reset_data: q=%h r=%h, want 0", bus.quotient, bus.remainder);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        dw_t  dvd;
        nw_t  eq, er;
        logic eo, ez;
        int   lat;
        dvd = (dw_t'(3) << N) | dw_t'(5);
        ref_div(dvd, nw_t'(7), eq, er, eo, ez);
        start_op(dvd, nw_t'(7));
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b want 1", bus.busy);
        end
        wait_done(lat);
        n_checks++;
        if (lat != LAT_CALC) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want %0d", lat, LAT_CALC);
        end
        n_checks++;
        if (bus.quotient !== eq || bus.remainder !== er) begin
            n_fail++;
            $display("FAIL basic_result: q=%h r=%h want q=%h r=%h", bus.quotient, bus.remainder, eq, er);
        end
        n_checks++;
        if (bus.ovf !== 1'b0 || bus.dz !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flags: ovf=%b dz=%b busy=%b want 0 0 0", bus.ovf, bus.dz, bus.busy);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", bus.done);
        end
    endtask

    task automatic test_back_to_back();
        dw_t  dvd1, dvd2;
        nw_t  dvs2, eq, er;
        logic eo, ez;
        int   lat;
        logic extra_done;
        dvd1 = (dw_t'(3) << N) | dw_t'(5);
        start_op(dvd1, nw_t'(7));
        repeat (49) @(posedge clk);
        #1;
        // second request mid-division must be dropped without disturbing the latched operands
        bus.dividend = {rand_n(), rand_n()};
        bus.divisor  = nw_t'(3);
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ref_div(dvd1, nw_t'(7), eq, er, eo, ez);
        wait_done(lat);
        n_checks++;
        if (lat != LAT_CALC) begin
            n_fail++;
            $display("FAIL ignored_start_latency: got %0d want %0d", lat, LAT_CALC);
        end
        n_checks++;
        if (bus.quotient !== eq || bus.remainder !== er) begin
            n_fail++;
            $display("FAIL ignored_start_result: q=%h r=%h want q=%h r=%h", bus.quotient, bus.remainder, eq, er);
        end
        @(posedge clk);
        #1;
        dvs2 = rand_n() | nw_t'(1);
        dvd2 = {rand_n() % dvs2, rand_n()};
        ref_div(dvd2, dvs2, eq, er, eo, ez);
        start_op(dvd2, dvs2);
        wait_done(lat);
        n_checks++;
        if (lat != LAT_CALC) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d want %0d", lat, LAT_CALC);
        end
        n_checks++;
        if (bus.quotient !== eq || bus.remainder !== er || bus.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result: q=%h r=%h ovf=%b want q=%h r=%h ovf=0", bus.quotient, bus.remainder, bus.ovf, eq, er);
        end
        extra_done = 1'b0;
        for (int i = 0; i < N + 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) extra_done = 1'b1;
        end
        n_checks++;
        if (extra_done !== 1'b0) begin
            n_fail++;
            $display("FAIL no_queued_start: extra done seen=%b want 0", extra_done);
        end
    endtask

    task automatic test_div_zero();
        dw_t dvd;
        int  lat;
        dvd = {rand_n(), rand_n()};
        start_op(dvd, '0);
        wait_done(lat);
        n_checks++;
        if (lat != LAT_OVF) begin
            n_fail++;
            $display("FAIL dz_latency: got %0d want %0d", lat, LAT_OVF);
        end
        n_checks++;
        if (bus.dz !== 1'b1 || bus.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL dz_flags: dz=%b ovf=%b want 1 1", bus.dz, bus.ovf);
        end
        n_checks++;
        if (bus.quotient !== {N{1'b1}} || bus.remainder !== dvd[N-1:0]) begin
            n_fail++;
            $display("FAIL dz_result: q=%h r=%h want all ones and r=%h", bus.quotient, bus.remainder, dvd[N-1:0]);
        end
    endtask

    task automatic test_ovf_clear();
        dw_t  dvd;
        nw_t  low, dvs2, eq, er;
        logic eo, ez;
        int   lat;
        low = rand_n();
        dvd = (dw_t'(5) << N) | dw_t'(low);
        start_op(dvd, nw_t'(5));
        wait_done(lat);
        n_checks++;
        if (lat != LAT_OVF) begin
            n_fail++;
            $display("FAIL ovf_latency: got %0d want %0d", lat, LAT_OVF);
        end
        n_checks++;
        if (bus.ovf !== 1'b1 || bus.dz !== 1'b0 || bus.quotient !== {N{1'b1}} || bus.remainder !== low) begin
            n_fail++;
            $display("FAIL ovf_result: ovf=%b dz=%b q=%h r=%h want 1 0 ones r=%h", bus.ovf, bus.dz, bus.quotient, bus.remainder, low);
        end
        @(posedge clk);
        #1;
        dvs2 = rand_n() | (nw_t'(1) << (N - 1));
        dvd  = {rand_n() >> 1, rand_n()};
        ref_div(dvd, dvs2, eq, er, eo, ez);
        start_op(dvd, dvs2);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (bus.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_held_over_start: ovf=%b want 1", bus.ovf);
        end
        wait_done(lat);
        n_checks++;
        if (lat != LAT_CALC || bus.ovf !== 1'b0 || bus.quotient !== eq || bus.remainder !== er) begin
            n_fail++;
            $display("FAIL ovf_cleared: lat=%0d ovf=%b q=%h r=%h want lat=%0d ovf=0 q=%h r=%h", lat, bus.ovf, bus.quotient, bus.remainder, LAT_CALC, eq, er);
        end
    endtask

    task automatic test_roundtrip(input int iters);
        nw_t a, b;
        dw_t prod;
        int  lat;
        for (int k = 0; k < iters; k++) begin
            a = rand_n();
            do b = rand_n() >> $urandom_range(0, N - 1); while (b == '0);
            prod = dw_t'(a) * dw_t'(b);
            start_op(prod, b);
            wait_done(lat);
            n_checks++;
            if (lat != LAT_CALC || bus.ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL rt_latency_ovf[%0d]: lat=%0d ovf=%b want %0d 0", k, lat, bus.ovf, LAT_CALC);
            end
            n_checks++;
            if (bus.quotient !== a || bus.remainder !== '0) begin
                n_fail++;
                $display("FAIL rt_result[%0d]: q=%h r=%h want q=%h r=0", k, bus.quotient, bus.remainder, a);
            end
            n_checks++;
            if (dw_t'(bus.quotient) * dw_t'(b) + dw_t'(bus.remainder) !== prod || !(bus.remainder < b)) begin
                n_fail++;
                $display("FAIL rt_invariant[%0d]: q=%h r=%h b=%h", k, bus.quotient, bus.remainder, b);
            end
        end
    endtask

    task automatic test_random(input int iters);
        dw_t  dvd;
        nw_t  dvs, eq, er;
        logic eo, ez;
        int   lat;
        for (int k = 0; k < iters; k++) begin
            dvd = {rand_n() >> $urandom_range(0, N - 1), rand_n()};
            dvs = rand_n() >> $urandom_range(0, N - 1);
            ref_div(dvd, dvs, eq, er, eo, ez);
            start_op(dvd, dvs);
            wait_done(lat);
            n_checks++;
            if (lat != (eo ? LAT_OVF : LAT_CALC)) begin
                n_fail++;
                $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, eo ? LAT_OVF : LAT_CALC);
            end
            n_checks++;
            if (bus.quotient !== eq || bus.remainder !== er || bus.ovf !== eo || bus.dz !== ez) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: q=%h r=%h ovf=%b dz=%b want q=%h r=%h ovf=%b dz=%b", k, bus.quotient, bus.remainder, bus.ovf, bus.dz, eq, er, eo, ez);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic stray;
        start_op((dw_t'(3) << N) | dw_t'(5), nw_t'(7));
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0 || bus.dz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ctrl: busy=%b done=%b ovf=%b dz=%b want 0", bus.busy, bus.done, bus.ovf, bus.dz);
        end
        n_checks++;
        if (bus.quotient !== '0 || bus.remainder !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_data: q=%h r=%h want 0", bus.quotient, bus.remainder);
        end
        stray = 1'b0;
        for (int i = 0; i < N + 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: activity after abort=%b want 0", stray);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ovf_clear();
        test_roundtrip(150);
        test_random(30);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
